// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 operand-fetch slice: opcodes, immediate kinds, micro-op layout.
// Also holds the immediate extender used by the field decoder.
package lc3_pkg;

    localparam int XLEN   = 16;
    localparam int NREG   = 8;
    localparam int RSEL_W = $clog2(NREG);

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_5    = 3'd1,
        IMM_6    = 3'd2,
        IMM_9    = 3'd3,
        IMM_11   = 3'd4,
        IMM_TRAP = 3'd5
    } imm_kind_t;

    typedef struct packed {
        opcode_t           op;
        logic [RSEL_W-1:0] dr;
        logic              wr_en;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [XLEN-1:0]   imm;
        logic              use_imm;
        logic [XLEN-1:0]   pc;
    } uop_t;

    function automatic logic [XLEN-1:0] imm_ext(input imm_kind_t kind, input logic [15:0] ir);
        logic [XLEN-1:0] v;
        case (kind)
            IMM_5:    v = {{(XLEN-5){ir[4]}},   ir[4:0]};
            IMM_6:    v = {{(XLEN-6){ir[5]}},   ir[5:0]};
            IMM_9:    v = {{(XLEN-9){ir[8]}},   ir[8:0]};
            IMM_11:   v = {{(XLEN-11){ir[10]}}, ir[10:0]};
            IMM_TRAP: v = {{(XLEN-8){1'b0}},    ir[7:0]};
            default:  v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/lc3_field_decode.sv
// Pure combinational LC-3 field decode: register selects, source usage, destination, immediate.
// Latency 0; no handshake of its own.
// Backpressure: none, the caller owns flow control.
module lc3_field_decode
    import lc3_pkg::*;
(
    input  logic [15:0]       ir,
    output logic [RSEL_W-1:0] sel1,
    output logic [RSEL_W-1:0] sel2,
    output logic              use1,
    output logic              use2,
    output logic              wr_en,
    output logic [RSEL_W-1:0] dest,
    output logic              use_imm,
    output logic [XLEN-1:0]   imm
);

    opcode_t   op;
    imm_kind_t kind;

    assign op = opcode_t'(ir[15:12]);

    always_comb begin
        sel1    = ir[8:6];
        sel2    = ir[2:0];
        use1    = 1'b0;
        use2    = 1'b0;
        wr_en   = 1'b0;
        dest    = ir[11:9];
        use_imm = 1'b0;
        kind    = IMM_NONE;
        case (op)
            OP_ADD, OP_AND: begin
                use1    = 1'b1;
                use2    = !ir[5];
                use_imm = ir[5];
                wr_en   = 1'b1;
                kind    = IMM_5;
            end
            OP_NOT: begin
                use1  = 1'b1;
                wr_en = 1'b1;
            end
            OP_LD, OP_LDI, OP_LEA: begin
                wr_en = 1'b1;
                kind  = IMM_9;
            end
            OP_LDR: begin
                use1  = 1'b1;
                wr_en = 1'b1;
                kind  = IMM_6;
            end
            // Stores read the data register through the second port.
            OP_ST, OP_STI: begin
                sel2 = ir[11:9];
                use2 = 1'b1;
                kind = IMM_9;
            end
            OP_STR: begin
                sel2 = ir[11:9];
                use1 = 1'b1;
                use2 = 1'b1;
                kind = IMM_6;
            end
            OP_BR: kind = IMM_9;
            OP_JSR: begin
                use1  = !ir[11];
                wr_en = 1'b1;
                dest  = 3'd7;
                kind  = ir[11] ? IMM_11 : IMM_NONE;
            end
            OP_JMP:  use1 = 1'b1;
            OP_TRAP: kind = IMM_TRAP;
            default: ;
        endcase
    end

    assign imm = imm_ext(kind, ir);

endmodule

// File: rtl/operand_fetch.sv
// LC-3 decode/operand fetch with RAW/WAW scoreboard; optional writeback bypass under OPFETCH_BYPASS_EN.
// Latency 1 cycle from accept to out_valid; output held stable until out_ready.
// Backpressure: in_ready drops on full-and-blocked output, on hazard stall, and during flush.
module operand_fetch
    import lc3_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_ir,
    input  logic [XLEN-1:0]   in_pc,
    output logic [RSEL_W-1:0] rf_sr1_sel,
    output logic [RSEL_W-1:0] rf_sr2_sel,
    input  logic [XLEN-1:0]   rf_sr1_data,
    input  logic [XLEN-1:0]   rf_sr2_data,
    input  logic              wb_valid,
    input  logic [RSEL_W-1:0] wb_dr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [RSEL_W-1:0] out_dr,
    output logic              out_wr_en,
    output logic [XLEN-1:0]   out_a,
    output logic [XLEN-1:0]   out_b,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_use_imm,
    output logic [XLEN-1:0]   out_pc
);

    logic [RSEL_W-1:0] dec_sel1;
    logic [RSEL_W-1:0] dec_sel2;
    logic              dec_use1;
    logic              dec_use2;
    logic              dec_wr_en;
    logic [RSEL_W-1:0] dec_dest;
    logic              dec_use_imm;
    logic [XLEN-1:0]   dec_imm;

    lc3_field_decode u_decode (
        .ir      (in_ir),
        .sel1    (dec_sel1),
        .sel2    (dec_sel2),
        .use1    (dec_use1),
        .use2    (dec_use2),
        .wr_en   (dec_wr_en),
        .dest    (dec_dest),
        .use_imm (dec_use_imm),
        .imm     (dec_imm)
    );

    assign rf_sr1_sel = dec_sel1;
    assign rf_sr2_sel = dec_sel2;

    logic [NREG-1:0] scoreboard;
    logic [NREG-1:0] sb_next;
    uop_t            uop_q;
    logic            out_valid_q;

    logic            byp1;
    logic            byp2;
    logic            byp_dst;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;

`ifdef OPFETCH_BYPASS_EN
    assign byp1    = wb_valid && (wb_dr == dec_sel1);
    assign byp2    = wb_valid && (wb_dr == dec_sel2);
    assign byp_dst = wb_valid && (wb_dr == dec_dest);
    assign opa     = byp1 ? wb_data : rf_sr1_data;
    assign opb     = byp2 ? wb_data : rf_sr2_data;
`else
    // The register file only updates at the edge, so a same-cycle writeback cannot help.
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign byp1    = 1'b0;
    assign byp2    = 1'b0;
    assign byp_dst = 1'b0;
    assign opa     = rf_sr1_data;
    assign opb     = rf_sr2_data;
`endif

    logic hazard;
    logic stall;
    logic fire;

    assign hazard = (dec_use1  && scoreboard[dec_sel1] && !byp1)
                  || (dec_use2  && scoreboard[dec_sel2] && !byp2)
                  || (dec_wr_en && scoreboard[dec_dest] && !byp_dst);
    assign stall    = in_valid && hazard;
    assign in_ready = (!out_valid_q || out_ready) && !stall && !flush;
    assign fire     = in_valid && in_ready;

    // Later assignments win: a set for a newly issued writer overrides any same-cycle clear.
    always_comb begin
        sb_next = scoreboard;
        if (wb_valid)
            sb_next[wb_dr] = 1'b0;
        if (flush && out_valid_q && uop_q.wr_en)
            sb_next[uop_q.dr] = 1'b0;
        if (fire && dec_wr_en)
            sb_next[dec_dest] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            uop_q       <= '0;
            scoreboard  <= '0;
        end else begin
            scoreboard <= sb_next;
            if (fire) begin
                out_valid_q   <= 1'b1;
                uop_q.op      <= opcode_t'(in_ir[15:12]);
                uop_q.dr      <= dec_dest;
                uop_q.wr_en   <= dec_wr_en;
                uop_q.a       <= opa;
                uop_q.b       <= opb;
                uop_q.imm     <= dec_imm;
                uop_q.use_imm <= dec_use_imm;
                uop_q.pc      <= in_pc;
            end else if (flush || out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op      = uop_q.op;
    assign out_dr      = uop_q.dr;
    assign out_wr_en   = uop_q.wr_en;
    assign out_a       = uop_q.a;
    assign out_b       = uop_q.b;
    assign out_imm     = uop_q.imm;
    assign out_use_imm = uop_q.use_imm;
    assign out_pc      = uop_q.pc;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: decode, scoreboard stalls, backpressure, flush and reset.
module tb_operand_fetch;
    import lc3_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ir;
    logic [15:0] in_pc;
    logic [2:0]  rf_sr1_sel;
    logic [2:0]  rf_sr2_sel;
    logic [15:0] rf_sr1_data;
    logic [15:0] rf_sr2_data;
    logic        wb_valid;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [2:0]  out_dr;
    logic        out_wr_en;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_imm;
    logic        out_use_imm;
    logic [15:0] out_pc;

    logic [15:0] rf [8];

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    assign rf_sr1_data = rf[rf_sr1_sel];
    assign rf_sr2_data = rf[rf_sr2_sel];

    operand_fetch dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ir       (in_ir),
        .in_pc       (in_pc),
        .rf_sr1_sel  (rf_sr1_sel),
        .rf_sr2_sel  (rf_sr2_sel),
        .rf_sr1_data (rf_sr1_data),
        .rf_sr2_data (rf_sr2_data),
        .wb_valid    (wb_valid),
        .wb_dr       (wb_dr),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_dr      (out_dr),
        .out_wr_en   (out_wr_en),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_imm     (out_imm),
        .out_use_imm (out_use_imm),
        .out_pc      (out_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset     = 1'b1;
        in_valid  = 1'b0;
        in_ir     = 16'h0000;
        in_pc     = 16'h0000;
        wb_valid  = 1'b0;
        wb_dr     = 3'd0;
        wb_data   = 16'h0000;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        rf[2] = 16'h0005;
        rf[4] = 16'h0044;
        rf[5] = 16'h0055;

        tick;
        tick;
        Reset = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sb", dut.scoreboard, 8'h00);
        chk("reset_out_a", out_a, 16'h0000);
        chk("reset_in_ready", in_ready, 1);

        // ADD R1,R2,#-3
        in_valid = 1'b1; in_ir = 16'h12BD; in_pc = 16'h3001;
        #1;
        chk("add_imm_ready", in_ready, 1);
        chk("add_imm_sel1", rf_sr1_sel, 3'd2);
        tick;
        chk("add_imm_valid", out_valid, 1);
        chk("add_imm_dr", out_dr, 3'd1);
        chk("add_imm_a", out_a, 16'h0005);
        chk("add_imm_imm", out_imm, 16'hFFFD);
        chk("add_imm_use_imm", out_use_imm, 1);
        chk("add_imm_wr_en", out_wr_en, 1);
        chk("add_imm_op", out_op, 4'h1);
        chk("add_imm_pc", out_pc, 16'h3001);
        chk("add_imm_sb", dut.scoreboard, 8'h02);

        // ADD R3,R1,R1 while R1 is pending, writeback of R1 arrives
        in_ir = 16'h1641; in_pc = 16'h3002;
        #1;
        chk("raw_stall", in_ready, 0);
        wb_valid = 1'b1; wb_dr = 3'd1; wb_data = 16'h0007;
        #1;
`ifdef OPFETCH_BYPASS_EN
        chk("bypass_ready", in_ready, 1);
        tick;
        wb_valid = 1'b0;
        rf[1] = 16'h0007;
`else
        chk("wb_same_cycle_stall", in_ready, 0);
        tick;
        wb_valid = 1'b0;
        rf[1] = 16'h0007;
        chk("stall_drain_valid", out_valid, 0);
        chk("wb_clear_sb", dut.scoreboard, 8'h00);
        #1;
        chk("after_wb_ready", in_ready, 1);
        tick;
`endif
        chk("raw_valid", out_valid, 1);
        chk("raw_a", out_a, 16'h0007);
        chk("raw_b", out_b, 16'h0007);
        chk("raw_dr", out_dr, 3'd3);
        chk("raw_use_imm", out_use_imm, 0);
        chk("raw_sb", dut.scoreboard, 8'h08);

        // STR R4,R5,#-1
        in_ir = 16'h797F; in_pc = 16'h3003;
        #1;
        chk("str_sel1", rf_sr1_sel, 3'd5);
        chk("str_sel2", rf_sr2_sel, 3'd4);
        chk("str_ready", in_ready, 1);
        tick;
        chk("str_wr_en", out_wr_en, 0);
        chk("str_imm", out_imm, 16'hFFFF);
        chk("str_a", out_a, 16'h0055);
        chk("str_b", out_b, 16'h0044);
        chk("str_sb", dut.scoreboard, 8'h08);

        // Backpressure: LEA R6 waits behind a held STR
        out_ready = 1'b0;
        in_ir = 16'hEC10; in_pc = 16'h3004;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            tick;
            chk("bp_valid", out_valid, 1);
            chk("bp_imm_stable", out_imm, 16'hFFFF);
            chk("bp_b_stable", out_b, 16'h0044);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick;
        chk("lea_op", out_op, 4'hE);
        chk("lea_dr", out_dr, 3'd6);
        chk("lea_imm", out_imm, 16'h0010);
        chk("lea_sb", dut.scoreboard, 8'h48);

        // Flush the held LEA
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick;
        chk("flush_valid", out_valid, 0);
        chk("flush_sb", dut.scoreboard, 8'h08);

        // Flush with nothing held; it also blocks an offered JSR
        in_valid = 1'b1; in_ir = 16'h4801; in_pc = 16'h3005; out_ready = 1'b1;
        #1;
        chk("flush_block_ready", in_ready, 0);
        tick;
        chk("flush_idle_valid", out_valid, 0);
        chk("flush_idle_sb", dut.scoreboard, 8'h08);
        flush = 1'b0;
        #1;
        chk("jsr_ready", in_ready, 1);
        tick;
        chk("jsr_valid", out_valid, 1);
        chk("jsr_dr", out_dr, 3'd7);
        chk("jsr_wr_en", out_wr_en, 1);
        chk("jsr_imm", out_imm, 16'h0001);
        chk("jsr_sb", dut.scoreboard, 8'h88);

        // TRAP x25
        in_ir = 16'hF025; in_pc = 16'h3006;
        tick;
        chk("trap_op", out_op, 4'hF);
        chk("trap_imm", out_imm, 16'h0025);
        chk("trap_wr_en", out_wr_en, 0);
        chk("trap_sb", dut.scoreboard, 8'h88);

        // Build scoreboard 8'h8A, stall, then reset
        in_ir = 16'h12BD; in_pc = 16'h3007;
        tick;
        chk("pre_reset_sb", dut.scoreboard, 8'h8A);
        in_ir = 16'h1641; in_pc = 16'h3008;
        #1;
        chk("pre_reset_stall", in_ready, 0);
        tick;
        chk("stall_out_valid", out_valid, 0);
        Reset = 1'b1;
        tick;
        chk("midstall_reset_sb", dut.scoreboard, 8'h00);
        chk("midstall_reset_valid", out_valid, 0);
        chk("midstall_reset_a", out_a, 16'h0000);
        Reset = 1'b0;
        #1;
        chk("midstall_reset_ready", in_ready, 1);
        in_valid = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
